// File: rtl/xmss_pkg.sv
// Shared XMSS definitions: sizes, domain pads, address word indices, WOTS chain FSM states.
package xmss_pkg;

  localparam int unsigned WOTS_W                = 16;
  localparam int unsigned WOTS_LOG_W            = $clog2(WOTS_W);
  localparam int unsigned STEP_W                = WOTS_LOG_W + 1;
  localparam int unsigned KEY_LEN               = 256;
  localparam int unsigned ADDR_W                = 256;
  localparam int unsigned MSG_W                 = 1024;
  localparam int unsigned WORD_W                = 32;
  localparam int unsigned XMSS_HASH_PADDING_F   = 0;
  localparam int unsigned XMSS_HASH_PADDING_PRF = 3;
  localparam int unsigned WORD_HASH             = 6;
  localparam int unsigned WORD_KM               = 7;

  // Hash core message-length encodings
  localparam logic MSG_LEN_768  = 1'b0;
  localparam logic MSG_LEN_1024 = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRF_KEY,
    ST_W_KEY,
    ST_PRF_MASK,
    ST_W_MASK,
    ST_F,
    ST_W_F,
    ST_DONE
  } wots_state_e;

  // Replace address word idx (word0 is the most significant word)
  function automatic logic [ADDR_W-1:0] set_addr_word(input logic [ADDR_W-1:0] addr,
                                                      input int unsigned        idx,
                                                      input logic [WORD_W-1:0]  val);
    logic [ADDR_W-1:0] r;
    r = addr;
    r[ADDR_W-1-WORD_W*idx -: WORD_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/wots_chain_if.sv
// Common hash-core request/response interface shared by the XMSS engines.
interface wots_chain_if;
  import xmss_pkg::*;

  logic                 hash_start;
  logic [MSG_W-1:0]     hash_data_in;
  logic                 message_length;
  logic                 store_intermediate;
  logic                 continue_intermediate;
  logic                 hash_done;
  logic [KEY_LEN-1:0]   hash_data_out;

  modport master (
    output hash_start, hash_data_in, message_length, store_intermediate, continue_intermediate,
    input  hash_done, hash_data_out
  );

  modport slave (
    input  hash_start, hash_data_in, message_length, store_intermediate, continue_intermediate,
    output hash_done, hash_data_out
  );
endinterface

// File: rtl/wots_chain_msg_fmt.sv
// PRF / F message packing: {pad, key, addr | data^mask, zero tail}, MSB-first.
module wots_chain_msg_fmt
  import xmss_pkg::*;
(
  input  logic               is_f,
  input  logic [KEY_LEN-1:0] seed,
  input  logic [KEY_LEN-1:0] k,
  input  logic [KEY_LEN-1:0] data,
  input  logic [KEY_LEN-1:0] mask,
  input  logic [ADDR_W-1:0]  addr,
  output logic [MSG_W-1:0]   msg_c
);

  // Select PRF (seed + address) or F (chain key + masked data) layout
  always_comb begin
    msg_c = '0;
    if (is_f) begin
      msg_c = {KEY_LEN'(XMSS_HASH_PADDING_F), k, data ^ mask, KEY_LEN'(0)};
    end else begin
      msg_c = {KEY_LEN'(XMSS_HASH_PADDING_PRF), seed, addr, KEY_LEN'(0)};
    end
  end

endmodule

// File: rtl/wots_chain.sv
// WOTS chain responder: iterates F from start_step to end_step-1 via the shared hash core.
// Optional build macro WOTS_CHAIN_HASH_CNT_EN adds a saturating hash request counter (hash_cnt).
module wots_chain
  import xmss_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LEN-1:0]    input_key,
  input  logic [KEY_LEN-1:0]    input_data,
  input  logic [WOTS_LOG_W-1:0] start_step,
  input  logic [WOTS_LOG_W-1:0] end_step,
  input  logic [ADDR_W-1:0]     hash_addr,
  output logic [KEY_LEN-1:0]    data_out,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_W-1:0]     hash_addr_updated,
`ifdef WOTS_CHAIN_HASH_CNT_EN
  output logic [15:0]           hash_cnt,
`endif
  wots_chain_if.master          hash
);

  wots_state_e        state_q, state_d;
  logic [KEY_LEN-1:0] seed_q, seed_d, data_q, data_d, k_q, k_d, mask_q, mask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [STEP_W-1:0]  step_q, step_d, end_q, end_d;
  logic               hash_start_d, is_f_d, done_d;
  logic [MSG_W-1:0]   msg_c;

  assign hash.message_length        = MSG_LEN_768;
  assign hash.store_intermediate    = 1'b0;
  assign hash.continue_intermediate = 1'b0;

  // Message is formed from next-cycle register values so it aligns with hash_start
  wots_chain_msg_fmt u_msg_fmt (
    .is_f  (is_f_d),
    .seed  (seed_d),
    .k     (k_d),
    .data  (data_d),
    .mask  (mask_d),
    .addr  (addr_d),
    .msg_c (msg_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    data_d       = data_q;
    k_d          = k_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    step_d       = step_q;
    end_d        = end_q;
    hash_start_d = 1'b0;
    is_f_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d  = input_key;
          data_d  = input_data;
          addr_d  = hash_addr;
          step_d  = STEP_W'(start_step);
          end_d   = STEP_W'(end_step);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (step_q >= end_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d       = set_addr_word(set_addr_word(addr_q, WORD_HASH, WORD_W'(step_q)),
                                       WORD_KM, WORD_W'(0));
          hash_start_d = 1'b1;
          state_d      = ST_PRF_KEY;
        end
      end
      ST_PRF_KEY:  state_d = ST_W_KEY;
      ST_W_KEY: begin
        if (hash.hash_done) begin
          k_d          = hash.hash_data_out;
          addr_d       = set_addr_word(addr_q, WORD_KM, WORD_W'(1));
          hash_start_d = 1'b1;
          state_d      = ST_PRF_MASK;
        end
      end
      ST_PRF_MASK: state_d = ST_W_MASK;
      ST_W_MASK: begin
        if (hash.hash_done) begin
          mask_d       = hash.hash_data_out;
          hash_start_d = 1'b1;
          is_f_d       = 1'b1;
          state_d      = ST_F;
        end
      end
      ST_F:        state_d = ST_W_F;
      ST_W_F: begin
        if (hash.hash_done) begin
          data_d  = hash.hash_data_out;
          step_d  = step_q + STEP_W'(1);
          state_d = ST_CHECK;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      seed_q            <= '0;
      data_q            <= '0;
      k_q               <= '0;
      mask_q            <= '0;
      addr_q            <= '0;
      step_q            <= '0;
      end_q             <= '0;
      done              <= 1'b0;
      busy              <= 1'b0;
      data_out          <= '0;
      hash_addr_updated <= '0;
      hash.hash_start   <= 1'b0;
      hash.hash_data_in <= '0;
    end else begin
      state_q         <= state_d;
      seed_q          <= seed_d;
      data_q          <= data_d;
      k_q             <= k_d;
      mask_q          <= mask_d;
      addr_q          <= addr_d;
      step_q          <= step_d;
      end_q           <= end_d;
      done            <= done_d;
      busy            <= (state_d != ST_IDLE);
      hash.hash_start <= hash_start_d;
      if (hash_start_d) hash.hash_data_in <= msg_c;
      if (done_d) begin
        data_out          <= data_q;
        hash_addr_updated <= addr_q;
      end
    end
  end

`ifdef WOTS_CHAIN_HASH_CNT_EN
  // Requests issued since the last accepted start, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_cnt <= '0;
    end else if (state_q == ST_IDLE && start) begin
      hash_cnt <= '0;
    end else if (hash_start_d && hash_cnt != 16'hFFFF) begin
      hash_cnt <= hash_cnt + 16'd1;
    end
  end
`endif

endmodule
